n_bit_isqrt: RTL and testbench
==============================

# n_bit_isqrt

Sequential integer square-root unit that consumes the 2N-bit product of the N-bit squarer stage and recovers an N-bit root plus remainder. It uses a restoring digit-by-digit algorithm at one root bit per clock, with valid/ready handshakes on both sides. It sits directly downstream of the squarer: it checks squarer results in loopback and serves any datapath needing floor(sqrt(x)) of a 2N-bit value.

## Interface
- N, default 4, root width; radicand width is 2N, remainder width is N+1; legal N ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  radicand present
- in_ready  output  1  unit can accept a radicand (high only in IDLE)
- radicand  input  2N  unsigned value, e.g. squarer result
- out_valid  output  1  root/rem valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- root  output  N  floor(sqrt(radicand))
- rem  output  N+1  radicand − root², range 0..2·root

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at a clock edge:
  - Latch radicand into shift register X.
  - Clear working remainder R (N+2 bits) and root Q (N bits).
  - Load iteration counter with N−1.
  - Go to CALC.
- CALC: exactly N iterations, one per clock:
  - R' = (R<<2) | X[2N-1:2N-2]; X <<= 2.
  - T = (Q<<2) | 1, evaluated at N+2 bits.
  - If R' ≥ T: R = R' − T, Q = (Q<<1)|1; else R = R', Q = Q<<1.
  - After the iteration with counter = 0, go to DONE; otherwise decrement the counter.
- DONE: out_valid=1; root=Q; rem=R[N:0].
  - Outputs hold stable until out_valid&&out_ready.
  - On that handshake, go to IDLE.
- in_ready=0 in CALC and DONE. in_valid and radicand are ignored there; there is no queuing and no same-edge re-accept in DONE.
- root/rem are registered and keep their last value in IDLE and CALC; they are meaningful only while out_valid=1.
- Arithmetic is unsigned throughout.
  - R never exceeds N+2 bits.
  - The final R ≤ 2·Q always fits in N+1 bits.
  - The subtraction never underflows because it is guarded by the compare.
- Boundary results:
  - radicand = 0 gives root=0, rem=0.
  - radicand = 2^(2N)−1 gives root=2^N−1, rem=2^(N+1)−2.
- Reset (any time, including mid-CALC or in DONE):
  - State goes to IDLE immediately and asynchronously.
  - in_ready=1 while rst_n is low and after release.
  - out_valid=0, root=0, rem=0; X, R, Q and the counter are cleared.
  - An in-flight operation is discarded with no output.

## Timing
- Acceptance edge = E0. The N CALC iterations occur on edges E1..EN.
- out_valid rises after EN: latency is N cycles from acceptance to out_valid.
- If out_ready is already high, the output handshake occurs at E(N+1). in_ready is high after E(N+1), so the next accept is possible at E(N+2).
- Maximum throughput is one result per N+2 cycles.
- Back-pressure: each extra cycle with out_ready=0 in DONE adds one cycle. Outputs must not glitch or change during the stall.
- No combinational paths from inputs to outputs:
  - in_ready and out_valid decode state registers only.
  - root/rem come directly from registers.

## Test plan
- N=4, radicand=0xE1 (225) with out_ready=1 → out_valid exactly 4 cycles after accept; root=15, rem=0; in_ready returns 1 cycle after the handshake.
- N=4, radicands 0, 1, 200, 255 back-to-back → (root, rem) = (0,0), (1,0), (14,4), (15,30).
- Stall: radicand=99, out_ready=0 for 5 cycles after out_valid → root=9 and rem=18 held constant; in_ready stays 0; in_valid pulses with radicand=50 during CALC/DONE are ignored; result after release is still 9/18.
- Reset mid-CALC (rst_n low 2 cycles after accepting 144) → out_valid=0, in_ready=1 immediately; after release, radicand=16 gives root=4, rem=0 with no stale 12 result.
- Loopback with the squarer, N=4: num=0..15 squared and fed in → root=num, rem=0 for all 16 values.
- Exhaustive N=4, radicand 0..255 plus random N=8 values → root² ≤ x < (root+1)² and rem = x − root² for every result; latency N on every transaction.

Source files
------------

// File: rtl/n_bit_isqrt_if.sv
// Handshake bundle for the integer square-root unit: radicand in, root/remainder out.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready are both high.
interface n_bit_isqrt_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] radicand;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   root;
  logic [N:0]     rem;

  modport master (
    output in_valid, radicand, out_ready,
    input  in_ready, out_valid, root, rem
  );

  modport slave (
    input  in_valid, radicand, out_ready,
    output in_ready, out_valid, root, rem
  );
endinterface

// File: rtl/n_bit_isqrt.sv
// Restoring digit-by-digit square root of a 2N-bit radicand, one root bit per clock.
// Outputs are registered; in_ready/out_valid decode the state register only.
module n_bit_isqrt #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  n_bit_isqrt_if.slave        bus,
  output logic [1:0]          state_dbg
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_nx;
  logic [2*N-1:0] x;
  logic [N+1:0]   r;
  logic [N-1:0]   q;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   root_r;
  logic [N:0]     rem_r;

  logic [N+1:0]   r_sh, t, r_nx;
  logic [N-1:0]   q_nx;
  logic           ge;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)      state_nx = CALC;
      CALC:    if (cnt == '0)         state_nx = DONE;
      DONE:    if (bus.out_ready)     state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.root      = root_r;
    bus.rem       = rem_r;
    state_dbg     = state;
  end

  // One restoring iteration; the compare guards the subtraction against underflow.
  always_comb begin
    r_sh = (r << 2) | (N+2)'(x[2*N-1 -: 2]);
    t    = {q, 2'b01};
    ge   = (r_sh >= t);
    r_nx = ge ? (r_sh - t) : r_sh;
    q_nx = (q << 1) | N'(ge);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      r      <= '0;
      q      <= '0;
      cnt    <= '0;
      root_r <= '0;
      rem_r  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x   <= bus.radicand;
          r   <= '0;
          q   <= '0;
          cnt <= CW'(N-1);
        end
        CALC: begin
          x <= x << 2;
          r <= r_nx;
          q <= q_nx;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Final remainder is at most 2*root, so N+1 bits always suffice.
            root_r <= q_nx;
            rem_r  <= r_nx[N:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_n_bit_isqrt.sv
// Directed bench for n_bit_isqrt: N=4 instance for timing/stall/reset cases, N=8 instance for wider values.
module tb_n_bit_isqrt;
  logic clk;
  logic rst_n;
  logic [1:0] st4, st8;

  int n_vec;
  int n_err;

  n_bit_isqrt_if #(.N(4)) b4 ();
  n_bit_isqrt_if #(.N(8)) b8 ();

  n_bit_isqrt #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave), .state_dbg(st4));
  n_bit_isqrt #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave), .state_dbg(st8));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt_model(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // One N=4 transaction; called at a negedge. stall>0 holds out_ready low that many cycles in DONE.
  task automatic op4(input string tag, input logic [7:0] rad, input logic [3:0] er,
                     input logic [4:0] erem, input int stall);
    int cyc;
    cyc = 0;
    while (!b4.in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk({tag, "_in_ready_pre"}, 32'(b4.in_ready), 32'd1);
    b4.in_valid  = 1'b1;
    b4.radicand  = rad;
    b4.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = (stall != 0);
    b4.radicand = (stall != 0) ? 8'd50 : rad;
    chk({tag, "_in_ready_calc"}, 32'(b4.in_ready), 32'd0);
    cyc = 0;
    while (!b4.out_valid && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
    chk({tag, "_latency"}, 32'(cyc), 32'd4);
    chk({tag, "_root"}, 32'(b4.root), 32'(er));
    chk({tag, "_rem"}, 32'(b4.rem), 32'(erem));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(b4.out_valid), 32'd1);
      chk({tag, "_stall_ready"}, 32'(b4.in_ready), 32'd0);
      chk({tag, "_stall_root"}, 32'(b4.root), 32'(er));
      chk({tag, "_stall_rem"}, 32'(b4.rem), 32'(erem));
    end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(b4.out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(b4.in_ready), 32'd1);
  endtask

  task automatic op8(input logic [15:0] rad);
    int cyc;
    int er;
    er = isqrt_model(int'(rad));
    b8.in_valid  = 1'b1;
    b8.radicand  = rad;
    b8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.in_valid = 1'b0;
    cyc = 0;
    while (!b8.out_valid && cyc < 30) begin @(posedge clk); @(negedge clk); cyc++; end
    chk("n8_latency", 32'(cyc), 32'd8);
    chk("n8_root", 32'(b8.root), 32'(er));
    chk("n8_rem", 32'(b8.rem), 32'(int'(rad) - er * er));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int er;
    n_vec = 0;
    n_err = 0;
    b4.in_valid = 1'b0; b4.radicand = '0; b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.radicand = '0; b8.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(b4.in_ready), 32'd1);
    chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst_root", 32'(b4.root), 32'd0);
    chk("rst_rem", 32'(b4.rem), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and back-to-back boundary values
    op4("v225", 8'd225, 4'd15, 5'd0, 0);
    op4("v0",   8'd0,   4'd0,  5'd0, 0);
    op4("v1",   8'd1,   4'd1,  5'd0, 0);
    op4("v200", 8'd200, 4'd14, 5'd4, 0);
    op4("v255", 8'd255, 4'd15, 5'd30, 0);

    // Back-pressure with ignored in_valid pulses
    op4("stall99", 8'd99, 4'd9, 5'd18, 5);

    // Reset mid-CALC discards the in-flight 144
    b4.in_valid = 1'b1; b4.radicand = 8'd144; b4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(b4.in_ready), 32'd1);
    chk("midrst_root", 32'(b4.root), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midrst_no_stale", 32'(b4.out_valid), 32'd0);
    op4("v16", 8'd16, 4'd4, 5'd0, 0);

    // Perfect squares, as produced by the squarer stage
    for (int n = 0; n < 16; n++) op4("sq", 8'(n * n), 4'(n), 5'd0, 0);

    // Exhaustive N=4 against the floor-sqrt model
    for (int v = 0; v < 256; v++) begin
      er = isqrt_model(v);
      op4("exh", 8'(v), 4'(er), 5'(v - er * er), 0);
    end

    // Wider instance: boundaries plus random values
    op8(16'd0);
    op8(16'hFFFF);
    op8(16'd1);
    for (int i = 0; i < 20; i++) op8(16'($urandom_range(0, 65535)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
